// File: rtl/postprocess_stream.sv
// rtl/postprocess_stream.sv - max-pool, NUM_OUT-channel FC, rescale/saturate, serial int8 result stream
// Optional argmax on out_class: define POSTPROCESS_ARGMAX_EN.
module postprocess_stream #(
  parameter int NUM_FEAT = 144,
  parameter int NUM_OUT  = 2,
  parameter int SHIFT    = 8,
  parameter int ACC_W    = 32,
  parameter int FEAT_W   = $clog2(NUM_FEAT),
  parameter int CH_W     = $clog2(NUM_OUT)
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    clear,
  input  logic                    relu_en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [7:0]       in_d0,
  input  logic signed [7:0]       in_d1,
  input  logic signed [7:0]       in_d2,
  input  logic signed [7:0]       in_d3,
  input  logic                    w_we,
  input  logic [CH_W-1:0]         w_ch,
  input  logic [FEAT_W-1:0]       w_addr,
  input  logic signed [7:0]       w_data,
  input  logic                    b_we,
  input  logic [CH_W-1:0]         b_ch,
  input  logic signed [ACC_W-1:0] b_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CH_W-1:0]         out_ch,
  output logic signed [7:0]       out_data,
  output logic                    out_last,
  output logic [CH_W-1:0]         out_class
);

  localparam int CH_N   = 2 ** CH_W;
  localparam int FEAT_N = 2 ** FEAT_W;
  localparam logic signed [ACC_W-1:0] ROUND  = ACC_W'(1) << (SHIFT - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = 127;
  localparam logic signed [ACC_W-1:0] SAT_LO = -128;

  typedef enum logic [1:0] {ST_ACC, ST_SCALE, ST_OUT} state_t;

  state_t                  state, state_nxt;
  logic [FEAT_W-1:0]       feat_cnt;
  logic [CH_W-1:0]         ch_cnt;
  logic signed [ACC_W-1:0] acc     [NUM_OUT];
  logic signed [7:0]       res     [NUM_OUT];
  logic signed [7:0]       scaled  [NUM_OUT];
  logic signed [15:0]      prod    [NUM_OUT];
  logic signed [7:0]       w_mem   [CH_N][FEAT_N];
  logic signed [ACC_W-1:0] b_reg   [CH_N];
  logic signed [7:0]       win_max;
  logic                    last_feat;
  logic                    last_ch;

  function automatic logic signed [7:0] smax(input logic signed [7:0] a, input logic signed [7:0] b);
    return (a > b) ? a : b;
  endfunction

  // Round half up, saturate to int8, then optional ReLU.
  function automatic logic signed [7:0] rescale(input logic signed [ACC_W-1:0] a,
                                                input logic signed [ACC_W-1:0] b,
                                                input logic                    relu);
    logic signed [ACC_W-1:0] s;
    logic signed [ACC_W-1:0] y;
    logic signed [7:0]       r;
    s = a + b + ROUND;
    y = s >>> SHIFT;
    if (y > SAT_HI)      r = 8'h7f;
    else if (y < SAT_LO) r = 8'h80;
    else                 r = y[7:0];
    if (relu && r[7]) r = '0;
    return r;
  endfunction

  assign win_max   = smax(smax(in_d0, in_d1), smax(in_d2, in_d3));
  assign last_feat = (feat_cnt == FEAT_W'(NUM_FEAT - 1));
  assign last_ch   = (ch_cnt == CH_W'(NUM_OUT - 1));

  assign in_ready  = (state == ST_ACC);
  assign out_valid = (state == ST_OUT);
  assign out_ch    = ch_cnt;
  assign out_data  = out_valid ? res[ch_cnt] : 8'sd0;
  assign out_last  = out_valid & last_ch;

  always_comb begin
    for (int ch = 0; ch < NUM_OUT; ch++) begin
      prod[ch]   = win_max * w_mem[ch][feat_cnt];
      scaled[ch] = rescale(acc[ch], b_reg[ch], relu_en);
    end
  end

  // Weight RAM and bias registers keep their contents across reset and clear.
  always_ff @(posedge clk) begin
    if (w_we) w_mem[w_ch][w_addr] <= w_data;
    if (b_we) b_reg[b_ch] <= b_data;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= ST_ACC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACC:   if (in_valid && last_feat) state_nxt = ST_SCALE;
      ST_SCALE: state_nxt = ST_OUT;
      ST_OUT:   if (out_ready && last_ch) state_nxt = ST_ACC;
      default:  state_nxt = ST_ACC;
    endcase
    if (clear) state_nxt = ST_ACC;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      feat_cnt <= '0;
      ch_cnt   <= '0;
      for (int ch = 0; ch < NUM_OUT; ch++) begin
        acc[ch] <= '0;
        res[ch] <= '0;
      end
    end else if (clear) begin
      feat_cnt <= '0;
      ch_cnt   <= '0;
      for (int ch = 0; ch < NUM_OUT; ch++) acc[ch] <= '0;
    end else begin
      case (state)
        ST_ACC: if (in_valid) begin
          for (int ch = 0; ch < NUM_OUT; ch++) acc[ch] <= acc[ch] + ACC_W'(prod[ch]);
          feat_cnt <= last_feat ? '0 : feat_cnt + 1'b1;
        end
        ST_SCALE: for (int ch = 0; ch < NUM_OUT; ch++) res[ch] <= scaled[ch];
        ST_OUT: if (out_ready) begin
          if (last_ch) begin
            ch_cnt <= '0;
            for (int ch = 0; ch < NUM_OUT; ch++) acc[ch] <= '0;
          end else begin
            ch_cnt <= ch_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef POSTPROCESS_ARGMAX_EN
  logic [CH_W-1:0]   best_idx;
  logic signed [7:0] best_val;
  logic [CH_W-1:0]   class_q;

  // Strict compare keeps the lowest index on a tie.
  always_comb begin
    best_idx = '0;
    best_val = scaled[0];
    for (int ch = 1; ch < NUM_OUT; ch++) begin
      if (scaled[ch] > best_val) begin
        best_val = scaled[ch];
        best_idx = CH_W'(ch);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                 class_q <= '0;
    else if (clear)             class_q <= '0;
    else if (state == ST_SCALE) class_q <= best_idx;
  end

  assign out_class = class_q;
`else
  assign out_class = '0;
`endif

endmodule

// File: tb/tb_postprocess_stream.sv
// tb/tb_postprocess_stream.sv - directed self-checking bench for postprocess_stream (NUM_FEAT=4, NUM_OUT=2, SHIFT=2)
module tb_postprocess_stream;

`ifdef POSTPROCESS_ARGMAX_EN
  localparam int ARG_EN = 1;
`else
  localparam int ARG_EN = 0;
`endif

  logic               clk = 1'b0;
  logic               rst_b;
  logic               clear;
  logic               relu_en;
  logic               in_valid;
  logic               in_ready;
  logic signed [7:0]  in_d0, in_d1, in_d2, in_d3;
  logic               w_we;
  logic [0:0]         w_ch;
  logic [1:0]         w_addr;
  logic signed [7:0]  w_data;
  logic               b_we;
  logic [0:0]         b_ch;
  logic signed [31:0] b_data;
  logic               out_valid;
  logic               out_ready;
  logic [0:0]         out_ch;
  logic signed [7:0]  out_data;
  logic               out_last;
  logic [0:0]         out_class;

  int errors = 0;
  int checks = 0;
  int beat [4][4];

  postprocess_stream #(.NUM_FEAT(4), .NUM_OUT(2), .SHIFT(2), .ACC_W(32)) dut (
    .clk(clk), .rst_b(rst_b), .clear(clear), .relu_en(relu_en),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_d0(in_d0), .in_d1(in_d1), .in_d2(in_d2), .in_d3(in_d3),
    .w_we(w_we), .w_ch(w_ch), .w_addr(w_addr), .w_data(w_data),
    .b_we(b_we), .b_ch(b_ch), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_data(out_data), .out_last(out_last), .out_class(out_class)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input int ch, input int addr, input int val);
    w_we = 1'b1; w_ch = 1'(ch); w_addr = 2'(addr); w_data = 8'(val);
    tick();
    w_we = 1'b0;
  endtask

  task automatic set_weights(input int a0, input int a1, input int a2, input int a3,
                             input int c0, input int c1, input int c2, input int c3);
    set_w(0, 0, a0); set_w(0, 1, a1); set_w(0, 2, a2); set_w(0, 3, a3);
    set_w(1, 0, c0); set_w(1, 1, c1); set_w(1, 2, c2); set_w(1, 3, c3);
  endtask

  task automatic set_b(input int ch, input int val);
    b_we = 1'b1; b_ch = 1'(ch); b_data = 32'(val);
    tick();
    b_we = 1'b0;
  endtask

  task automatic drive_beat(input int i);
    in_d0 = 8'(beat[i][0]); in_d1 = 8'(beat[i][1]);
    in_d2 = 8'(beat[i][2]); in_d3 = 8'(beat[i][3]);
  endtask

  task automatic basic_beats();
    for (int i = 0; i < 4; i++) beat[i] = '{10, -3, 2, 0};
  endtask

  // Four beats, then SCALE, then OUT with optional backpressure before the handshakes.
  task automatic run_frame(input string tag, input int e0, input int e1, input int ec, input int hold);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      drive_beat(i);
      tick();
    end
    in_valid = 1'b0;
    check({tag, ".scale_valid"}, int'(out_valid), 0);
    check({tag, ".scale_ready"}, int'(in_ready), 0);
    tick();
    out_ready = (hold == 0);
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      check({tag, ".bp_valid"}, int'(out_valid), 1);
      check({tag, ".bp_ch"}, int'(out_ch), 0);
      check({tag, ".bp_data"}, int'(out_data), e0);
      check({tag, ".bp_ready"}, int'(in_ready), 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({tag, ".v0"}, int'(out_valid), 1);
    check({tag, ".ch0"}, int'(out_ch), 0);
    check({tag, ".d0"}, int'(out_data), e0);
    check({tag, ".last0"}, int'(out_last), 0);
    check({tag, ".class0"}, int'(out_class), ec);
    tick();
    check({tag, ".v1"}, int'(out_valid), 1);
    check({tag, ".ch1"}, int'(out_ch), 1);
    check({tag, ".d1"}, int'(out_data), e1);
    check({tag, ".last1"}, int'(out_last), 1);
    check({tag, ".class1"}, int'(out_class), ec);
    tick();
    check({tag, ".done_valid"}, int'(out_valid), 0);
    check({tag, ".done_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    rst_b = 1'b0; clear = 1'b0; relu_en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_d0 = '0; in_d1 = '0; in_d2 = '0; in_d3 = '0;
    w_we = 1'b0; w_ch = '0; w_addr = '0; w_data = '0;
    b_we = 1'b0; b_ch = '0; b_data = '0;
    tick(); tick();
    check("rst.out_valid", int'(out_valid), 0);
    check("rst.in_ready", int'(in_ready), 1);
    check("rst.out_data", int'(out_data), 0);
    check("rst.out_ch", int'(out_ch), 0);
    check("rst.out_last", int'(out_last), 0);
    check("rst.out_class", int'(out_class), 0);
    rst_b = 1'b1;
    tick();

    set_weights(1, 1, 1, 1, -1, -1, -1, -1);
    set_b(0, 0); set_b(1, 0);
    basic_beats();
    run_frame("basic", 10, -10, 0, 0);

    relu_en = 1'b1;
    run_frame("relu", 10, 0, 0, 0);
    relu_en = 1'b0;

    set_b(0, 1000); set_b(1, -1000);
    run_frame("sat", 127, -128, 0, 0);
    set_b(0, 0); set_b(1, 0);

    run_frame("bp", 10, -10, 0, 5);
    run_frame("after_bp", 10, -10, 0, 0);

    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      drive_beat(i);
      tick();
    end
    clear = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    check("clear.ready", int'(in_ready), 1);
    check("clear.valid", int'(out_valid), 0);
    run_frame("clear", 10, -10, 0, 0);

    // acc0 = 7+8-6+36 = 45 -> 11; acc1 = -7+0-2-18 = -27 -> -7
    set_weights(1, 2, 3, 4, -1, 0, 1, -2);
    beat[0] = '{-5, 7, -1, 3};
    beat[1] = '{1, 2, 3, 4};
    beat[2] = '{-8, -2, -6, -4};
    beat[3] = '{0, 0, 0, 9};
    run_frame("varied", 11, -7, 0, 0);

    basic_beats();
    set_weights(1, 1, 1, 1, 1, 1, 1, 1);
    run_frame("tie", 10, 10, 0, 0);
    set_weights(1, 1, 1, 1, 2, 2, 2, 2);
    run_frame("argmax", 10, 20, ARG_EN, 0);

    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      drive_beat(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("prerst.valid", int'(out_valid), 1);
    rst_b = 1'b0;
    #1;
    check("midrst.valid", int'(out_valid), 0);
    check("midrst.ready", int'(in_ready), 1);
    check("midrst.class", int'(out_class), 0);
    tick();
    rst_b = 1'b1;
    tick();
    run_frame("post_rst", 10, 20, ARG_EN, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
